riscv_dmem_ctrl: RTL and testbench

- Data-memory access controller, directly downstream of the byte-lane/alignment stage in the MEM pipeline stage.
- Takes the aligned address, write data and byte-select produced for each load/store and runs one access on a req/gnt/rvalid data-memory bus.
- Stalls the pipeline until the bus responds, then returns the raw read word for load extraction.
- Flags bus errors and response timeouts.

---
 rtl/riscv_dmem_ctrl_pkg.sv | 18 +
 rtl/riscv_dmem_ctrl_timer.sv | 41 ++++
 rtl/riscv_dmem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_riscv_dmem_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_ctrl_pkg.sv
// Shared configuration for the data-memory access controller: bus width,
// FSM state encodings and the default response timeout.
package riscv_dmem_ctrl_pkg;

   localparam int XLEN                     = 32;
   localparam int DMEM_CTRL_TIMEOUT_CYCLES = 64;

   localparam logic [1:0] DMEM_CTRL_IDLE = 2'd0;
   localparam logic [1:0] DMEM_CTRL_REQ  = 2'd1;
   localparam logic [1:0] DMEM_CTRL_WAIT = 2'd2;
   localparam logic [1:0] DMEM_CTRL_DONE = 2'd3;

   // One extra bit so the counter can hold TIMEOUT_CYCLES itself.
   function automatic int dmem_ctrl_cnt_w(input int timeout_cycles);
      return $clog2(timeout_cycles) + 1;
   endfunction

endpackage

// File: rtl/riscv_dmem_ctrl_timer.sv
// Loadable saturating up-counter with a terminal-count flag; shared by the
// data-side and fetch-side bus controllers for response timeouts.
module riscv_dmem_ctrl_timer #(
   parameter int WIDTH    = 7,
   parameter int TERMINAL = 63
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_tc
);

   localparam logic [WIDTH-1:0] TC_VAL  = WIDTH'(TERMINAL);
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Saturate instead of wrapping so the flag cannot fall back to 0 on a long stall.
   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_load_val;
      end else if (i_en && (count_q != CNT_MAX)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_tc = (count_q >= TC_VAL);

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// MEM-stage data-memory controller: runs one req/gnt/rvalid bus access per
// load/store, stalls the pipeline until the response, reports errors/timeouts.
//
// state | meaning
// IDLE  | no access; a pipeline request is registered onto the bus outputs
// REQ   | o_bus_req high, bus outputs held until grant
// WAIT  | granted, waiting for the response (rvalid)
// DONE  | completion cycle: stall released, error pulse shown
module riscv_dmem_ctrl #(
   parameter int XLEN           = riscv_dmem_ctrl_pkg::XLEN,
   parameter int TIMEOUT_CYCLES = riscv_dmem_ctrl_pkg::DMEM_CTRL_TIMEOUT_CYCLES
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_dmem_ctrl_req,
   input  logic              i_dmem_ctrl_wen,
   input  logic [XLEN-1:0]   i_dmem_ctrl_addr,
   input  logic [XLEN-1:0]   i_dmem_ctrl_wr_data,
   input  logic [XLEN/8-1:0] i_dmem_ctrl_byte_sel,
   output logic [XLEN-1:0]   o_dmem_ctrl_rd_data,
   output logic              o_dmem_ctrl_stall,
   output logic              o_dmem_ctrl_err,
   output logic              o_bus_req,
   output logic              o_bus_we,
   output logic [XLEN-1:0]   o_bus_addr,
   output logic [XLEN-1:0]   o_bus_wdata,
   output logic [XLEN/8-1:0] o_bus_be,
   input  logic              i_bus_gnt,
   input  logic              i_bus_rvalid,
   input  logic [XLEN-1:0]   i_bus_rdata,
   input  logic              i_bus_err
);

   import riscv_dmem_ctrl_pkg::*;

   localparam int              CNT_W     = dmem_ctrl_cnt_w(TIMEOUT_CYCLES);
   localparam logic [XLEN-1:0] ADDR_MASK = ~(XLEN'(3));

   logic [1:0]        state_q,     state_d;
   logic              bus_req_q,   bus_req_d;
   logic              bus_we_q,    bus_we_d;
   logic [XLEN-1:0]   bus_addr_q,  bus_addr_d;
   logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
   logic [XLEN/8-1:0] bus_be_q,    bus_be_d;
   logic [XLEN-1:0]   rd_data_q,   rd_data_d;
   logic              err_q,       err_d;
   logic              flush_q,     flush_d;

   logic tmr_load;
   logic tmr_en;
   logic tmr_tc;
   logic discard;

   assign tmr_en  = (state_q == DMEM_CTRL_REQ) || (state_q == DMEM_CTRL_WAIT);
   // A flushed access still finishes on the bus but must not touch rd_data/err.
   assign discard = flush_q || !i_dmem_ctrl_req;

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      rd_data_d   = rd_data_q;
      err_d       = 1'b0;
      flush_d     = flush_q;
      tmr_load    = 1'b0;

      case (state_q)
         DMEM_CTRL_IDLE: begin
            if (i_dmem_ctrl_req) begin
               state_d     = DMEM_CTRL_REQ;
               bus_req_d   = 1'b1;
               bus_we_d    = i_dmem_ctrl_wen;
               bus_addr_d  = i_dmem_ctrl_addr & ADDR_MASK;
               bus_wdata_d = i_dmem_ctrl_wr_data;
               bus_be_d    = i_dmem_ctrl_wen ? i_dmem_ctrl_byte_sel : '1;
               flush_d     = 1'b0;
               tmr_load    = 1'b1;
            end
         end

         DMEM_CTRL_REQ: begin
            if (!i_dmem_ctrl_req) begin
               flush_d = 1'b1;
            end
            if (i_bus_gnt) begin
               state_d   = DMEM_CTRL_WAIT;
               bus_req_d = 1'b0;
            end else if (tmr_tc) begin
               state_d   = DMEM_CTRL_DONE;
               bus_req_d = 1'b0;
               if (!discard) begin
                  rd_data_d = '0;
                  err_d     = 1'b1;
               end
            end
         end

         DMEM_CTRL_WAIT: begin
            if (!i_dmem_ctrl_req) begin
               flush_d = 1'b1;
            end
            if (i_bus_rvalid) begin
               state_d = DMEM_CTRL_DONE;
               if (!discard) begin
                  if (!bus_we_q) begin
                     rd_data_d = i_bus_rdata;
                  end
                  err_d = i_bus_err;
               end
            end else if (tmr_tc) begin
               state_d = DMEM_CTRL_DONE;
               if (!discard) begin
                  rd_data_d = '0;
                  err_d     = 1'b1;
               end
            end
         end

         DMEM_CTRL_DONE: begin
            state_d = DMEM_CTRL_IDLE;
         end

         default: begin
            state_d = DMEM_CTRL_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= DMEM_CTRL_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
         rd_data_q   <= '0;
         err_q       <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         rd_data_q   <= rd_data_d;
         err_q       <= err_d;
         flush_q     <= flush_d;
      end
   end

   riscv_dmem_ctrl_timer #(
      .WIDTH    (CNT_W),
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_load     (tmr_load),
      .i_load_val ('0),
      .i_en       (tmr_en),
      .o_tc       (tmr_tc)
   );

   assign o_dmem_ctrl_stall   = i_dmem_ctrl_req && (state_q != DMEM_CTRL_DONE);
   assign o_dmem_ctrl_rd_data = rd_data_q;
   assign o_dmem_ctrl_err     = err_q;
   assign o_bus_req           = bus_req_q;
   assign o_bus_we            = bus_we_q;
   assign o_bus_addr          = bus_addr_q;
   assign o_bus_wdata         = bus_wdata_q;
   assign o_bus_be            = bus_be_q;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Bench for riscv_dmem_ctrl: directed table of accesses, hand-written reset and
// back-to-back sequences, and randomized accesses against a cycle-walk model.
module tb_riscv_dmem_ctrl;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req, wen;
   logic [31:0] addr, wdata;
   logic [3:0]  bsel;
   logic [31:0] rd_data;
   logic        stall, err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        gnt, rvalid, berr;
   logic [31:0] rdata;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model_rd = '0;

   riscv_dmem_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut (
      .i_clk                (clk),
      .i_rstn               (rstn),
      .i_dmem_ctrl_req      (req),
      .i_dmem_ctrl_wen      (wen),
      .i_dmem_ctrl_addr     (addr),
      .i_dmem_ctrl_wr_data  (wdata),
      .i_dmem_ctrl_byte_sel (bsel),
      .o_dmem_ctrl_rd_data  (rd_data),
      .o_dmem_ctrl_stall    (stall),
      .o_dmem_ctrl_err      (err),
      .o_bus_req            (bus_req),
      .o_bus_we             (bus_we),
      .o_bus_addr           (bus_addr),
      .o_bus_wdata          (bus_wdata),
      .o_bus_be             (bus_be),
      .i_bus_gnt            (gnt),
      .i_bus_rvalid         (rvalid),
      .i_bus_rdata          (rdata),
      .i_bus_err            (berr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          g;
      int          r;
      bit          berr;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      bit          exp_err;
      logic [31:0] exp_rd;
      int          exp_stall;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Cycle index c counts bus cycles from the first REQ cycle. The grant at c==g
   // and the response at c==g+1+r take priority; otherwise an access whose
   // counter has reached T-1 is aborted in that cycle.
   function automatic void walk(input int g, input int r, output int done_c, output bit tmo);
      bit granted;
      granted = 1'b0;
      done_c  = 0;
      tmo     = 1'b1;
      for (int c = 0; c < 256; c++) begin
         if (!granted) begin
            if (c == g) granted = 1'b1;
            else if (c >= T - 1) begin
               done_c = c; tmo = 1'b1; return;
            end
         end else begin
            if (c == g + 1 + r) begin
               done_c = c; tmo = 1'b0; return;
            end
            if (c >= T - 1) begin
               done_c = c; tmo = 1'b1; return;
            end
         end
      end
   endfunction

   // Cycle n=0 is the IDLE cycle where the request is first seen.
   task automatic run_access(input bit we_i, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input int g, input int r,
                             input bit be_err, input logic [31:0] rdat,
                             output logic [31:0] o_addr, output logic [3:0] o_be,
                             output logic o_err, output logic [31:0] o_rd,
                             output int o_stall_cnt);
      int          done_c, nd, req_end, last;
      bit          tmo;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      walk(g, r, done_c, tmo);
      nd       = done_c + 2;
      req_end  = 1 + ((g < done_c) ? g : done_c);
      last     = ((nd > 2 + g + r) ? nd : 2 + g + r) + 1;
      exp_addr = {a[31:2], 2'b00};
      exp_be   = we_i ? be : 4'hF;
      o_addr = '0; o_be = '0; o_err = 1'b0; o_rd = '0; o_stall_cnt = 0;
      for (int n = 0; n <= last; n++) begin
         @(negedge clk);
         req    = (n <= nd);
         wen    = we_i;
         addr   = a;
         wdata  = wd;
         bsel   = be;
         gnt    = (n == 1 + g);
         rvalid = (n == 2 + g + r);
         rdata  = rvalid ? rdat : $urandom;
         berr   = rvalid ? be_err : 1'($urandom);
         #1;
         if (n == nd) begin
            if (tmo) model_rd = '0;
            else if (!we_i) model_rd = rdat;
         end
         if (stall) o_stall_cnt++;
         if (n == 1) begin o_addr = bus_addr; o_be = bus_be; end
         if (n == nd) begin o_err = err; o_rd = rd_data; end
         chk("stall", 32'(stall), 32'(n < nd));
         chk("bus_req", 32'(bus_req), 32'(n >= 1 && n <= req_end));
         chk("err", 32'(err), 32'((n == nd) && (tmo || be_err)));
         chk("rd_data", rd_data, model_rd);
         if (n >= 1 && n <= req_end) begin
            chk("bus_addr", bus_addr, exp_addr);
            chk("bus_be", 32'(bus_be), 32'(exp_be));
            chk("bus_we", 32'(bus_we), 32'(we_i));
            if (we_i) chk("bus_wdata", bus_wdata, wd);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] o_addr, o_rd;
      logic [3:0]  o_be;
      logic        o_err;
      int          o_sc;

      rstn = 1'b0; req = 0; wen = 0; addr = 0; wdata = 0; bsel = 0;
      gnt = 0; rvalid = 0; rdata = 0; berr = 0;
      #2;
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_be", 32'(bus_be), 0);
      chk("rst_bus_we", 32'(bus_we), 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_stall", 32'(stall), 0);
      @(negedge clk);
      rstn = 1'b1;

      //         we  addr          wdata         be    g   r  berr rdata         exp_addr      be    err exp_rd        stall
      tbl[0] = '{1'b0, 32'h0000_1006, 32'h0,        4'h0, 0,  0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1004, 4'hF, 1'b0, 32'hDEAD_BEEF, 3};
      tbl[1] = '{1'b1, 32'h0000_0020, 32'h00AB_0000, 4'h4, 4,  0, 1'b0, 32'h1234_5678, 32'h0000_0020, 4'h4, 1'b0, 32'hDEAD_BEEF, 7};
      tbl[2] = '{1'b0, 32'h0000_0044, 32'h0,        4'h0, 1,  2, 1'b1, 32'hCAFE_F00D, 32'h0000_0044, 4'hF, 1'b1, 32'hCAFE_F00D, 6};
      tbl[3] = '{1'b0, 32'h0000_0100, 32'h0,        4'h0, 9,  0, 1'b0, 32'h7777_7777, 32'h0000_0100, 4'hF, 1'b1, 32'h0,         9};
      tbl[4] = '{1'b0, 32'h0000_0203, 32'h0,        4'h0, 0,  0, 1'b0, 32'h5A5A_5A5A, 32'h0000_0200, 4'hF, 1'b0, 32'h5A5A_5A5A, 3};
      tbl[5] = '{1'b1, 32'h0000_0007, 32'h0000_BEEF, 4'h3, 2,  9, 1'b0, 32'h9999_9999, 32'h0000_0004, 4'h3, 1'b1, 32'h0,         9};

      for (int i = 0; i < 6; i++) begin
         run_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].g, tbl[i].r,
                    tbl[i].berr, tbl[i].rdata, o_addr, o_be, o_err, o_rd, o_sc);
         chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].exp_addr);
         chk($sformatf("tbl%0d_be", i), 32'(o_be), 32'(tbl[i].exp_be));
         chk($sformatf("tbl%0d_err", i), 32'(o_err), 32'(tbl[i].exp_err));
         chk($sformatf("tbl%0d_rd", i), o_rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_stall_cycles", i), 32'(o_sc), 32'(tbl[i].exp_stall));
      end

      // Reset while waiting for the response.
      @(negedge clk); req = 1; wen = 0; addr = 32'h300; gnt = 0; rvalid = 0;
      @(negedge clk); gnt = 1; #1; chk("rstseq_bus_req", 32'(bus_req), 1);
      @(negedge clk); gnt = 0; #1; chk("rstseq_wait_stall", 32'(stall), 1);
      rstn = 1'b0; req = 0; #1;
      chk("rstseq_bus_req_async", 32'(bus_req), 0);
      chk("rstseq_stall_async", 32'(stall), 0);
      chk("rstseq_err_async", 32'(err), 0);
      chk("rstseq_bus_addr_async", bus_addr, 0);
      chk("rstseq_rd_async", rd_data, 0);
      model_rd = '0;
      @(negedge clk); rstn = 1'b1;
      @(negedge clk); rvalid = 1; rdata = 32'hBAD0_BAD0; #1;
      chk("rstseq_stray_stall", 32'(stall), 0);
      @(negedge clk); rvalid = 0; #1;
      chk("rstseq_stray_rd", rd_data, 0);
      chk("rstseq_stray_err", 32'(err), 0);
      run_access(1'b0, 32'h0000_0304, 32'h0, 4'h0, 0, 1, 1'b0, 32'h0BAD_CAFE,
                 o_addr, o_be, o_err, o_rd, o_sc);
      chk("rstseq_after_rd", o_rd, 32'h0BAD_CAFE);

      // Back-to-back loads with req held through DONE.
      @(negedge clk); req = 1; wen = 0; addr = 32'h400; gnt = 0; rvalid = 0; #1;
      chk("b2b_n0_stall", 32'(stall), 1);
      @(negedge clk); gnt = 1; #1;
      chk("b2b_n1_bus_req", 32'(bus_req), 1);
      chk("b2b_n1_addr", bus_addr, 32'h400);
      @(negedge clk); gnt = 0; rvalid = 1; rdata = 32'h1111_1111; #1;
      chk("b2b_n2_stall", 32'(stall), 1);
      @(negedge clk); rvalid = 0; #1;
      chk("b2b_n3_stall", 32'(stall), 0);
      chk("b2b_n3_rd", rd_data, 32'h1111_1111);
      @(negedge clk); addr = 32'h404; #1;
      chk("b2b_n4_stall", 32'(stall), 1);
      chk("b2b_n4_bus_req", 32'(bus_req), 0);
      @(negedge clk); gnt = 1; #1;
      chk("b2b_n5_bus_req", 32'(bus_req), 1);
      chk("b2b_n5_addr", bus_addr, 32'h404);
      @(negedge clk); gnt = 0; rvalid = 1; rdata = 32'h2222_2222; #1;
      chk("b2b_n6_rd_hold", rd_data, 32'h1111_1111);
      @(negedge clk); rvalid = 0; #1;
      chk("b2b_n7_rd", rd_data, 32'h2222_2222);
      chk("b2b_n7_stall", 32'(stall), 0);
      @(negedge clk); req = 0; #1;
      chk("b2b_n8_bus_req", 32'(bus_req), 0);
      model_rd = 32'h2222_2222;

      // Randomized accesses against the cycle-walk model.
      for (int i = 0; i < 40; i++) begin
         bit          rwe, rerr;
         logic [31:0] ra, rwd, rrd;
         logic [3:0]  rbe;
         int          rg, rr;
         rwe  = 1'($urandom);
         ra   = $urandom;
         rwd  = $urandom;
         rbe  = 4'($urandom_range(1, 15));
         rg   = $urandom_range(0, 10);
         rr   = $urandom_range(0, 8);
         rerr = ($urandom_range(0, 3) == 0);
         rrd  = $urandom;
         run_access(rwe, ra, rwd, rbe, rg, rr, rerr, rrd, o_addr, o_be, o_err, o_rd, o_sc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
